// File: rtl/cordic_job_arbiter.sv
// cordic_job_arbiter: shares one CORDIC controller between p_NUM_REQ requesters.
// Jobs are accepted round-robin over per-requester valid/ready, issued to the
// controller with a one-cycle start, and results are returned to the granted
// requester over valid/ready once the controller writes back "ready".
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready       : per-requester job handshake (ready is combinational)
//   req_x/y/z, req_ctrl       : packed per-requester operands / control low half
//   rsp_valid/rsp_ready       : per-requester result handshake
//   rsp_x/y/z, rsp_flags      : shared result bus, controller flags at completion
//   rsp_timeout               : job was force-stopped by the watchdog
//   cor_*                     : controller bus (operands, control in/out, write enable, results)
//   busy, grant_id            : arbiter status
//
// Optional: define CORDIC_ARB_WATCHDOG_EN to force the controller's stop bit
// once a job has spent p_TIMEOUT cycles waiting for completion.
module cordic_job_arbiter #(
    parameter int unsigned p_WIDTH    = 32,
    parameter int unsigned p_NUM_REQ  = 4,
    parameter int unsigned p_ID_WIDTH = 2,
    parameter int unsigned p_TIMEOUT  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [p_NUM_REQ-1:0]         req_valid,
    output logic [p_NUM_REQ-1:0]         req_ready,
    input  logic [p_NUM_REQ*p_WIDTH-1:0] req_x,
    input  logic [p_NUM_REQ*p_WIDTH-1:0] req_y,
    input  logic [p_NUM_REQ*p_WIDTH-1:0] req_z,
    input  logic [p_NUM_REQ*16-1:0]      req_ctrl,
    output logic [p_NUM_REQ-1:0]         rsp_valid,
    input  logic [p_NUM_REQ-1:0]         rsp_ready,
    output logic [p_WIDTH-1:0]           rsp_x,
    output logic [p_WIDTH-1:0]           rsp_y,
    output logic [p_WIDTH-1:0]           rsp_z,
    output logic [15:0]                  rsp_flags,
    output logic                         rsp_timeout,
    output logic [p_WIDTH-1:0]           cor_x_in,
    output logic [p_WIDTH-1:0]           cor_y_in,
    output logic [p_WIDTH-1:0]           cor_z_in,
    output logic [31:0]                  cor_ctrl_in,
    input  logic [31:0]                  cor_ctrl_out,
    input  logic                         cor_ctrl_we,
    input  logic [p_WIDTH-1:0]           cor_x_res,
    input  logic [p_WIDTH-1:0]           cor_y_res,
    input  logic [p_WIDTH-1:0]           cor_z_res,
    output logic                         busy,
    output logic [p_ID_WIDTH-1:0]        grant_id
);

    localparam logic [p_NUM_REQ-1:0]  ONE_HOT = p_NUM_REQ'(1);
    localparam logic [p_ID_WIDTH-1:0] LAST_ID = p_ID_WIDTH'(p_NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t                  state;
    state_t                  stateNext;
    logic [p_ID_WIDTH-1:0]   rrPtr;
    logic [p_ID_WIDTH-1:0]   winner;
    logic                    winnerFound;
    logic                    accept;
    logic                    complete;
    logic                    handshake;
    logic                    wdStop;
    logic [p_WIDTH-1:0]      jobX;
    logic [p_WIDTH-1:0]      jobY;
    logic [p_WIDTH-1:0]      jobZ;
    logic [15:0]             jobCtrl;
    logic                    unusedBits;

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        int unsigned idx;
        winnerFound = 1'b0;
        winner      = '0;
        idx         = 0;
        for (int unsigned k = 0; k < p_NUM_REQ; k++) begin
            idx = (32'(rrPtr) + k) % p_NUM_REQ;
            if (!winnerFound && req_valid[p_ID_WIDTH'(idx)]) begin
                winnerFound = 1'b1;
                winner      = p_ID_WIDTH'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    // Next-state logic and handshake strobes. The start-acknowledge write-back
    // (we=1, ready=0) is not a completion.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        complete  = 1'b0;
        handshake = 1'b0;
        case (state)
            IDLE: begin
                if (winnerFound) begin
                    accept    = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: stateNext = WAIT;
            WAIT: begin
                if (cor_ctrl_we && cor_ctrl_out[16]) begin
                    complete  = 1'b1;
                    stateNext = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_ready[grant_id]) begin
                    handshake = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Job capture, result capture and pointer update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jobX      <= '0;
            jobY      <= '0;
            jobZ      <= '0;
            jobCtrl   <= '0;
            grant_id  <= '0;
            rrPtr     <= '0;
            rsp_valid <= '0;
            rsp_x     <= '0;
            rsp_y     <= '0;
            rsp_z     <= '0;
            rsp_flags <= '0;
        end else begin
            if (accept) begin
                jobX     <= req_x[32'(winner)*p_WIDTH +: p_WIDTH];
                jobY     <= req_y[32'(winner)*p_WIDTH +: p_WIDTH];
                jobZ     <= req_z[32'(winner)*p_WIDTH +: p_WIDTH];
                jobCtrl  <= req_ctrl[32'(winner)*16 +: 16];
                grant_id <= winner;
            end
            if (complete) begin
                rsp_valid <= ONE_HOT << grant_id;
                rsp_x     <= cor_x_res;
                rsp_y     <= cor_y_res;
                rsp_z     <= cor_z_res;
                rsp_flags <= cor_ctrl_out[31:16];
            end
            if (handshake) begin
                rsp_valid <= '0;
                rrPtr     <= (grant_id == LAST_ID) ? '0 : grant_id + p_ID_WIDTH'(1);
            end
        end
    end

`ifdef CORDIC_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(p_TIMEOUT + 1);

    logic [WD_W-1:0] wdCnt;

    assign wdStop = (state == WAIT) && (wdCnt == WD_W'(p_TIMEOUT));

    // Wait-cycle counter, saturating at the timeout; result flag per job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdCnt       <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            if (state == ISSUE)              wdCnt <= '0;
            else if (state == WAIT && !wdStop) wdCnt <= wdCnt + WD_W'(1);
            if (accept)        rsp_timeout <= 1'b0;
            else if (complete) rsp_timeout <= wdStop;
        end
    end

    assign unusedBits = ^{cor_ctrl_out[15:0], jobCtrl[1:0]};
`else
    assign wdStop      = 1'b0;
    assign rsp_timeout = 1'b0;
    assign unusedBits  = ^{cor_ctrl_out[15:0], jobCtrl[1:0], 32'(p_TIMEOUT)};
`endif

    // Controller control word: start pulse in ISSUE, stop only from the watchdog.
    always_comb begin
        cor_ctrl_in = '0;
        if (state == ISSUE) cor_ctrl_in = {16'b0, jobCtrl[15:2], 1'b0, 1'b1};
        if (wdStop)         cor_ctrl_in[1] = 1'b1;
    end

    assign req_ready = (rst && state == IDLE && winnerFound) ? (ONE_HOT << winner) : '0;
    assign cor_x_in  = jobX;
    assign cor_y_in  = jobY;
    assign cor_z_in  = jobZ;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_cordic_job_arbiter.sv
// Self-checking bench for cordic_job_arbiter (default build, watchdog disabled).
// A small controller stand-in answers start pulses; a transaction-level model
// predicts grants, start words and responses.
module tb_cordic_job_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0]  req_x, req_y, req_z;
    logic [N*16-1:0] req_ctrl;
    logic [W-1:0]    rsp_x, rsp_y, rsp_z;
    logic [15:0]     rsp_flags;
    logic            rsp_timeout, busy, cor_ctrl_we;
    logic [W-1:0]    cor_x_in, cor_y_in, cor_z_in, cor_x_res, cor_y_res, cor_z_res;
    logic [31:0]     cor_ctrl_in, cor_ctrl_out;
    logic [1:0]      grant_id;

    cordic_job_arbiter #(.p_WIDTH(W), .p_NUM_REQ(N), .p_ID_WIDTH(2), .p_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_ctrl(req_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_flags(rsp_flags),
        .rsp_timeout(rsp_timeout),
        .cor_x_in(cor_x_in), .cor_y_in(cor_y_in), .cor_z_in(cor_z_in),
        .cor_ctrl_in(cor_ctrl_in), .cor_ctrl_out(cor_ctrl_out), .cor_ctrl_we(cor_ctrl_we),
        .cor_x_res(cor_x_res), .cor_y_res(cor_y_res), .cor_z_res(cor_z_res),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int passCnt = 0;
    int checkCnt = 0;

    // Requester side
    logic [N-1:0] pend;
    logic [31:0]  jx[N], jy[N], jz[N];
    logic [15:0]  jc[N];
    bit           keepAll, rndReady;
    int           holdCnt;

    // Reference model
    int          ptr, owner, acceptCyc, cyc;
    bit          mBusy, rspOut;
    logic [31:0] ex, ey, ez, erx, ery, erz;
    logic [15:0] ec, expFlags;

    // Controller stand-in
    int          ackCyc, doneCyc;
    logic [31:0] sx, sy, sz;
    logic [15:0] sc;

    // Observations
    int          starts;
    logic [31:0] startWordSeen;
    logic [15:0] flagsSeen;
    int          dutLog[$];

    typedef struct {
        int          req;
        logic [31:0] x, y, z;
        logic [15:0] ctrl;
        int          hold;
        logic [31:0] expStart;
        logic [15:0] expFlags;
    } vec_t;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Controller behaviour used by both the stand-in and the model.
    function automatic logic [15:0] flagsOf(logic [31:0] x, logic [31:0] y, logic [15:0] c);
        logic err;
        err = (c[3:2] == 2'b01) && (x <= y);
        return {8'h5A ^ x[7:0], 6'b0, err, 1'b1};
    endfunction

    function automatic int pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic int idxOf(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic post(int i, logic [31:0] x, logic [31:0] y, logic [31:0] z, logic [15:0] c);
        pend[i] = 1'b1;
        jx[i] = x; jy[i] = y; jz[i] = z; jc[i] = c;
    endtask

    task automatic postRandom(int i);
        logic [15:0] c;
        c = {3'b0, 5'($urandom_range(0, 5)), 8'($urandom)};
        post(i, $urandom, $urandom, $urandom, c);
    endtask

    // One clock: drive at negedge, check, then advance the model at posedge.
    task automatic cycle();
        int w;
        logic [N-1:0] rr;
        bit doDone, doHs;
        if (cyc == doneCyc) begin
            cor_ctrl_we  = 1'b1;
            cor_ctrl_out = {flagsOf(sx, sy, sc), sc};
            cor_x_res    = sx ^ 32'hFFFF0000;
            cor_y_res    = sy + 32'd7;
            cor_z_res    = ~sz;
        end else begin
            cor_ctrl_we  = (cyc == ackCyc);
            cor_ctrl_out = (cyc == ackCyc) ? ($urandom & 32'hFFFE_FFFF) : $urandom;
            cor_x_res    = $urandom;
            cor_y_res    = $urandom;
            cor_z_res    = $urandom;
        end
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W]     = jx[i];
            req_y[i*W +: W]     = jy[i];
            req_z[i*W +: W]     = jz[i];
            req_ctrl[i*16 +: 16] = jc[i];
        end
        rr = rndReady ? 4'($urandom) : 4'hF;
        if (rspOut && holdCnt > 0) begin
            rr[owner] = 1'b0;
            holdCnt--;
        end
        rsp_ready = rr;
        #1;
        w = mBusy ? -1 : pick(pend, ptr);
        chk("req_ready", 64'(req_ready), (w >= 0) ? 64'(1 << w) : 64'd0);
        chk("busy", 64'(busy), 64'(mBusy));
        if (mBusy) begin
            chk("grant_id", 64'(grant_id), 64'(owner));
            chk("cor_x_in", 64'(cor_x_in), 64'(ex));
            chk("cor_y_in", 64'(cor_y_in), 64'(ey));
            chk("cor_z_in", 64'(cor_z_in), 64'(ez));
        end
        chk("cor_ctrl_in", 64'(cor_ctrl_in),
            (mBusy && cyc == acceptCyc + 1) ? 64'({16'h0, ec[15:2], 2'b01}) : 64'd0);
        chk("rsp_valid", 64'(rsp_valid), rspOut ? 64'(1 << owner) : 64'd0);
        if (rspOut) begin
            chk("rsp_x", 64'(rsp_x), 64'(erx));
            chk("rsp_y", 64'(rsp_y), 64'(ery));
            chk("rsp_z", 64'(rsp_z), 64'(erz));
            chk("rsp_flags", 64'(rsp_flags), 64'(expFlags));
        end
        chk("rsp_timeout", 64'(rsp_timeout), 64'd0);
        if (cor_ctrl_in[0]) begin
            starts++;
            startWordSeen = cor_ctrl_in;
            ackCyc  = cyc + 1;
            doneCyc = cyc + 2 + int'(cor_ctrl_in[12:8]);
            sx = cor_x_in; sy = cor_y_in; sz = cor_z_in; sc = cor_ctrl_in[15:0];
        end
        if (req_ready != '0) dutLog.push_back(idxOf(req_ready));
        if (rspOut) flagsSeen = rsp_flags;
        doDone = mBusy && !rspOut && (cyc == doneCyc);
        doHs   = rspOut && rr[owner];
        @(posedge clk);
        if (w >= 0) begin
            mBusy = 1'b1; owner = w; acceptCyc = cyc;
            ex = jx[w]; ey = jy[w]; ez = jz[w]; ec = jc[w];
            pend[w] = 1'b0;
            if (keepAll) postRandom(w);
        end
        if (doDone) begin
            rspOut   = 1'b1;
            erx      = ex ^ 32'hFFFF0000;
            ery      = ey + 32'd7;
            erz      = ~ez;
            expFlags = flagsOf(ex, ey, ec);
        end
        if (doHs) begin
            rspOut = 1'b0;
            mBusy  = 1'b0;
            ptr    = (owner + 1) % N;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(int maxCycles);
        int n = 0;
        while ((mBusy || pend != '0) && n < maxCycles) begin
            cycle();
            n++;
        end
        chk("drain", 64'({mBusy, pend}), 64'd0);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{0, 32'h26DD3B6A, 32'h0,        32'h20000000, 16'h1F0C, 0,  32'h00001F0D, 16'h3001};
        vecs[1] = '{1, 32'h10000000, 32'h20000000, 32'h0,        16'h1F04, 10, 32'h00001F05, 16'h5A03};
        vecs[2] = '{3, 32'h12345678, 32'h00000010, 32'hFFFFFFFF, 16'h0307, 2,  32'h00000305, 16'h2201};
        vecs[3] = '{2, 32'h00000001, 32'h00000001, 32'h0,        16'h0006, 0,  32'h00000005, 16'h5B03};

        pend = '0; keepAll = 0; rndReady = 0; holdCnt = 0;
        ptr = 0; owner = 0; acceptCyc = -10; cyc = 0; mBusy = 0; rspOut = 0;
        ackCyc = -1; doneCyc = -1; starts = 0; startWordSeen = '0; flagsSeen = '0;
        for (int i = 0; i < N; i++) begin jx[i] = '0; jy[i] = '0; jz[i] = '0; jc[i] = '0; end
        rst = 1'b0;
        req_valid = '1; rsp_ready = '0; req_x = '0; req_y = '0; req_z = '0; req_ctrl = '0;
        cor_ctrl_we = 1'b0; cor_ctrl_out = '0; cor_x_res = '0; cor_y_res = '0; cor_z_res = '0;
        #1;
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset cor_ctrl_in", 64'(cor_ctrl_in), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed jobs, one at a time
        foreach (vecs[v]) begin
            post(vecs[v].req, vecs[v].x, vecs[v].y, vecs[v].z, vecs[v].ctrl);
            holdCnt = vecs[v].hold;
            starts = 0;
            drain(200);
            chk("start pulses", 64'(starts), 64'd1);
            chk("start word", 64'(startWordSeen), 64'(vecs[v].expStart));
            chk("done flags", 64'(flagsSeen), 64'(vecs[v].expFlags));
        end

        // Back-pressure with other requesters waiting
        post(1, 32'hCAFEF00D, 32'h1, 32'h2, 16'h0208);
        holdCnt = 10;
        for (int n = 0; n < 50 && !rspOut; n++) cycle();
        post(0, 32'h11111111, 32'h2, 32'h3, 16'h0108);
        post(2, 32'h22222222, 32'h3, 32'h4, 16'h0108);
        dutLog.delete();
        repeat (10) cycle();
        chk("no accept under back-pressure", 64'(dutLog.size()), 64'd0);
        drain(300);

        // Reset during WAIT aborts the job
        post(2, 32'h0BADBEEF, 32'h5, 32'h6, 16'h1408);
        for (int n = 0; n < 100 && !(mBusy && cyc >= acceptCyc + 4); n++) cycle();
        rst = 1'b0;
        cor_ctrl_we = 1'b0;
        req_valid = '1;
        #1;
        chk("mid-job reset req_ready", 64'(req_ready), 64'd0);
        chk("mid-job reset busy", 64'(busy), 64'd0);
        chk("mid-job reset grant_id", 64'(grant_id), 64'd0);
        chk("mid-job reset cor_ctrl_in", 64'(cor_ctrl_in), 64'd0);
        chk("mid-job reset cor_x_in", 64'(cor_x_in), 64'd0);
        chk("mid-job reset rsp", 64'({rsp_valid, rsp_x, rsp_flags, rsp_timeout}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mBusy = 0; rspOut = 0; ptr = 0; ackCyc = -1; doneCyc = -1; holdCnt = 0;
        pend = '0;
        post(3, 32'h3, 32'h3, 32'h3, 16'h0108);
        post(2, 32'h2, 32'h2, 32'h2, 16'h0108);
        post(0, 32'h0, 32'h0, 32'h0, 16'h0108);
        dutLog.delete();
        drain(300);
        chk("post-reset first grant", 64'(dutLog.size() > 0 ? dutLog[0] : -1), 64'd0);

        // Round-robin with all requesters continuously valid, pointer at 0
        keepAll = 1;
        for (int i = 0; i < N; i++) postRandom(i);
        dutLog.delete();
        for (int n = 0; n < 400 && dutLog.size() < 5; n++) cycle();
        keepAll = 0;
        begin
            int order[5] = '{0, 1, 2, 3, 0};
            for (int k = 0; k < 5; k++)
                chk("rr order", 64'(dutLog.size() > k ? dutLog[k] : -1), 64'(order[k]));
        end
        drain(600);

        // Random traffic with random result back-pressure
        rndReady = 1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 5) == 0) postRandom(i);
            cycle();
        end
        drain(1000);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
